// File: rtl/ir_command_receiver.sv
// ir_command_receiver: decodes SIRC-style pulse-width IR frames (start mark
// plus NUM_BITS data bits, LSB first) into a move command for the rover.
// The line is active-low: ir_in = 0 means carrier present (a "mark").
module ir_command_receiver #(
    parameter int unsigned START_MIN = 48600,
    parameter int unsigned START_MAX = 81000,
    parameter int unsigned ZERO_MIN  = 8100,
    parameter int unsigned ONE_MIN   = 24300,
    parameter int unsigned BIT_MAX   = 40500,
    parameter int unsigned SPACE_MAX = 24300,
    parameter int unsigned NUM_BITS  = 12
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ir_in,
    output logic [NUM_BITS-1:0] move_command,
    output logic                command_valid,
    output logic                frame_error,
    output logic                busy
);

    localparam int CNT_W = 18;
    localparam int BIT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    localparam logic [CNT_W-1:0] START_MIN_C = CNT_W'(START_MIN);
    localparam logic [CNT_W-1:0] START_MAX_C = CNT_W'(START_MAX);
    localparam logic [CNT_W-1:0] ZERO_MIN_C  = CNT_W'(ZERO_MIN);
    localparam logic [CNT_W-1:0] ONE_MIN_C   = CNT_W'(ONE_MIN);
    localparam logic [CNT_W-1:0] BIT_MAX_C   = CNT_W'(BIT_MAX);
    localparam logic [CNT_W-1:0] SPACE_MAX_C = CNT_W'(SPACE_MAX);
    localparam logic [BIT_W-1:0] LAST_BIT_C  = BIT_W'(NUM_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_MARK,
        SPACE,
        BIT_MARK,
        DONE,
        WAIT_CLEAR
    } state_t;

    state_t              state, next_state;
    logic                sync1, sync2;
    logic                mark, mark_q;
    logic                mark_rise, mark_fall;
    logic [CNT_W-1:0]    dur_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [NUM_BITS-1:0] shift_reg;

    logic                abort;
    logic                shift_en;
    logic                bit_val;
    logic                clr_bits;
    logic                inc_bits;

    assign mark      = ~sync2;
    assign mark_rise = mark & ~mark_q;
    assign mark_fall = ~mark & mark_q;
    assign busy      = (state != IDLE);

    // Two-flop synchronizer on the raw sensor line plus the edge-detect copy.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would collapse the synchronizer chain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            mark_q <= 1'b0;
        end else begin
            sync1  <= ir_in;
            sync2  <= sync1;
            mark_q <= mark;
        end
    end

    // Mark/space duration counter: restarts on every mark edge, saturates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dur_cnt <= '0;
        end else if (mark_rise || mark_fall) begin
            dur_cnt <= '0;
        end else if (dur_cnt != '1) begin
            dur_cnt <= dur_cnt + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: classifies each mark/space by its measured length.
    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        next_state = state;
        abort      = 1'b0;
        shift_en   = 1'b0;
        bit_val    = 1'b0;
        clr_bits   = 1'b0;
        inc_bits   = 1'b0;
        case (state)
            IDLE: begin
                // Only a fresh rising edge starts a frame; a held mark is ignored.
                if (mark_rise) next_state = START_MARK;
            end
            START_MARK: begin
                if (mark_fall) begin
                    if (dur_cnt < START_MIN_C) begin
                        next_state = IDLE;          // glitch, dropped silently
                    end else begin
                        next_state = SPACE;
                        clr_bits   = 1'b1;
                    end
                end else if (dur_cnt >= START_MAX_C) begin
                    abort      = 1'b1;
                    next_state = WAIT_CLEAR;
                end
            end
            SPACE: begin
                if (mark_rise) begin
                    next_state = BIT_MARK;
                end else if (dur_cnt >= SPACE_MAX_C) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end
            end
            BIT_MARK: begin
                if (mark_fall) begin
                    if (dur_cnt < ZERO_MIN_C) begin
                        abort      = 1'b1;
                        next_state = IDLE;
                    end else begin
                        shift_en = 1'b1;
                        bit_val  = (dur_cnt >= ONE_MIN_C);
                        if (bit_cnt == LAST_BIT_C) begin
                            next_state = DONE;
                        end else begin
                            inc_bits   = 1'b1;
                            next_state = SPACE;
                        end
                    end
                end else if (dur_cnt >= BIT_MAX_C) begin
                    abort      = 1'b1;
                    next_state = WAIT_CLEAR;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            WAIT_CLEAR: begin
                if (!mark) next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Bit counter and LSB-first shift register (new bit enters at the MSB).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (clr_bits) begin
                bit_cnt <= '0;
            end else if (inc_bits) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift_en) begin
                shift_reg <= {bit_val, shift_reg[NUM_BITS-1:1]};
            end
        end
    end

    // Registered outputs: command is published only from DONE; strobes last one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            move_command  <= '0;
            command_valid <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            command_valid <= (state == DONE);
            frame_error   <= abort;
            if (state == DONE) begin
                move_command <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_ir_command_receiver.sv
// Self-checking bench for ir_command_receiver. Timing parameters are scaled
// down by 270 (one bench clock per 10 us) so whole frames stay short.
module tb_ir_command_receiver;

    localparam int START_MIN = 180;
    localparam int START_MAX = 300;
    localparam int ZERO_MIN  = 30;
    localparam int ONE_MIN   = 90;
    localparam int BIT_MAX   = 150;
    localparam int SPACE_MAX = 90;
    localparam int NUM_BITS  = 12;

    logic        clock;
    logic        reset;
    logic        ir_in;
    logic [11:0] move_command;
    logic        command_valid;
    logic        frame_error;
    logic        busy;

    typedef struct {
        bit          is_err;
        logic [11:0] value;
        int          lo;
        int          hi;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [11:0] model_last = 12'h000;

    ir_command_receiver #(
        .START_MIN(START_MIN), .START_MAX(START_MAX), .ZERO_MIN(ZERO_MIN),
        .ONE_MIN(ONE_MIN), .BIT_MAX(BIT_MAX), .SPACE_MAX(SPACE_MAX),
        .NUM_BITS(NUM_BITS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ir_in(ir_in),
        .move_command(move_command),
        .command_valid(command_valid),
        .frame_error(frame_error),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: at cycle %0d, expected within [%0d,%0d]", name, act, lo, hi);
        end
    endtask

    task automatic push_valid(input logic [11:0] v, input int at);
        exp_t x;
        x.is_err = 1'b0; x.value = v; x.lo = at; x.hi = at;
        sb.push_back(x);
        model_last = v;
    endtask

    task automatic push_err(input int lo, input int hi);
        exp_t x;
        x.is_err = 1'b1; x.value = 12'h000; x.lo = lo; x.hi = hi;
        sb.push_back(x);
    endtask

    // Line idle (no carrier) for n clocks.
    task automatic idle(input int n);
        ir_in = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    // Carrier for n clocks; returns right as the line goes idle again.
    task automatic mark(input int n);
        ir_in = 1'b0;
        repeat (n) @(negedge clock);
        ir_in = 1'b1;
    endtask

    task automatic do_reset();
        idle(10);
        reset = 1'b0;
        #1;
        check("rst_move_command", {20'd0, move_command}, 32'd0);
        check("rst_command_valid", {31'd0, command_valid}, 32'd0);
        check("rst_frame_error", {31'd0, frame_error}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        model_last = 12'h000;
    endtask

    // Encodes v as a frame and records the outcome the protocol rules imply.
    // nbits < 12 truncates the frame; bad_last makes the final mark too short;
    // reset_after pulses reset after that bit index (-1 for none).
    task automatic send_frame(input logic [11:0] v, input int nbits, input bit fixed,
                              input int reset_after, input bit bad_last);
        int len;
        bit was_reset;
        was_reset = 1'b0;
        mark(fixed ? 240 : int'($urandom_range(280, 200)));
        for (int i = 0; i < nbits; i++) begin
            idle(fixed ? 60 : int'($urandom_range(70, 20)));
            if (bad_last && i == nbits - 1) len = int'($urandom_range(20, 5));
            else if (v[i]) len = fixed ? 120 : int'($urandom_range(140, 100));
            else len = fixed ? 60 : int'($urandom_range(80, 40));
            mark(len);
            if (bad_last && i == nbits - 1) push_err(cyc, cyc + 6);
            else if (i == NUM_BITS - 1 && !was_reset) push_valid(v, cyc + 4);
            if (i == reset_after) begin
                do_reset();
                was_reset = 1'b1;
            end
        end
        if (nbits < NUM_BITS && !bad_last && !was_reset)
            push_err(cyc + SPACE_MAX, cyc + SPACE_MAX + 6);
    endtask

    // Monitor: every strobe pops one expectation; an expectation whose window
    // passes without a strobe is reported as missing.
    always @(negedge clock) begin
        if (command_valid || frame_error) begin
            check("strobe_exclusive", {31'd0, command_valid & frame_error}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", {30'd0, frame_error, command_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("strobe_kind", {31'd0, frame_error}, {31'd0, e.is_err});
                if (!e.is_err) check("move_command", {20'd0, move_command}, {20'd0, e.value});
                check_range("strobe_time", cyc, e.lo, e.hi);
            end
        end else if (sb.size() != 0 && cyc > sb[0].hi) begin
            e = sb.pop_front();
            check_range("missing_strobe", cyc, e.lo, e.hi);
        end
    end

    initial begin
        int t0;
        int kind;
        logic [11:0] v;

        reset = 1'b0;
        ir_in = 1'b1;
        @(negedge clock);
        check("init_move_command", {20'd0, move_command}, 32'd0);
        check("init_strobes", {30'd0, command_valid, frame_error}, 32'd0);
        check("init_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        idle(20);

        // Nominal frame, then the same frame three times at 45 ms spacing.
        send_frame(12'h305, NUM_BITS, 1'b1, -1, 1'b0);
        idle(100);
        for (int r = 0; r < 3; r++) begin
            t0 = cyc;
            send_frame(12'h305, NUM_BITS, 1'b1, -1, 1'b0);
            idle(4500 - (cyc - t0));
        end
        check("repeat_hold", {20'd0, move_command}, 32'h305);

        // Glitch in IDLE, then a valid frame.
        mark(10);
        idle(100);
        send_frame(12'hA0F, NUM_BITS, 1'b1, -1, 1'b0);
        idle(100);

        // Truncated frame: start plus 5 bits, then 2 ms of idle line.
        send_frame(12'h3C6, 5, 1'b1, -1, 1'b0);
        idle(200);
        check("trunc_busy", {31'd0, busy}, 32'd0);
        check("trunc_hold", {20'd0, move_command}, {20'd0, model_last});

        // Stuck mark of 5 ms.
        ir_in = 1'b0;
        push_err(cyc + START_MAX, cyc + START_MAX + 6);
        repeat (400) @(negedge clock);
        check("stuck_busy", {31'd0, busy}, 32'd1);
        repeat (100) @(negedge clock);
        idle(10);
        check("stuck_release_busy", {31'd0, busy}, 32'd0);
        check("stuck_hold", {20'd0, move_command}, {20'd0, model_last});
        send_frame(12'h5A3, NUM_BITS, 1'b1, -1, 1'b0);
        idle(100);

        // Reset mid-frame after bit 6, then a clean frame.
        send_frame(12'h3E9, NUM_BITS, 1'b1, 5, 1'b0);
        idle(100);
        check("post_reset_hold", {20'd0, move_command}, 32'd0);
        send_frame(12'h0FF, NUM_BITS, 1'b1, -1, 1'b0);
        idle(100);

        // Randomized frames with randomized timing and occasional faults.
        for (int n = 0; n < 12; n++) begin
            v = 12'($urandom);
            kind = int'($urandom_range(3, 0));
            if (kind == 0) begin
                send_frame(v, int'($urandom_range(11, 1)), 1'b0, -1, 1'b0);
                idle(200);
                check("rand_trunc_busy", {31'd0, busy}, 32'd0);
                check("rand_trunc_hold", {20'd0, move_command}, {20'd0, model_last});
            end else if (kind == 1) begin
                send_frame(v, int'($urandom_range(12, 1)), 1'b0, -1, 1'b1);
                idle(150);
                check("rand_short_hold", {20'd0, move_command}, {20'd0, model_last});
            end else begin
                send_frame(v, NUM_BITS, 1'b0, -1, 1'b0);
            end
            idle(int'($urandom_range(300, 10)));
        end

        idle(50);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
